// File: rtl/mips_pipelined_cpu_if.sv
// Program-load strobe and full debug observation bus of the pipelined MIPS core.
// The core connects through the slave modport. The bench or host connects through the master modport.
interface mips_pipelined_cpu_if;
    logic        I_MIPS_WrPM;
    logic [31:0] I_MIPS_WrDataPM;
    logic [31:0] O_PC, O_PC_NEXT, O_ID_PC, O_ID_INSTR;
    logic [19:0] O_EXE_CONTROL, O_MEM_CONTROL, O_WB_CONTROL;
    logic [31:0] O_EXE_PC, O_EXE_READ_DATA1, O_EXE_READ_DATA2, O_EXE_SIGN_EXT, O_EXE_SHIFT;
    logic [4:0]  O_EXE_RS, O_EXE_RT, O_EXE_RD, O_MEM_REGDST, O_WB_REGDST;
    logic [31:0] O_MEM_ALU_RESULT, O_MEM_WRITE_DATA, O_MEM_PC, O_MEM_SHIFT;
    logic [31:0] O_WB_PC, O_WB_ADDR, O_WB_READ_DATA, O_WB_SHIFT;
    logic        O_HZ_IFID_WRITE, O_HZ_PC_WRITE, O_HZ_ID_ControlMux;
    logic [1:0]  O_FU_ForwardA, O_FU_ForwardB;
    logic [31:0] O_PM_REG [32];
    logic [31:0] O_DM_REG [32];
    logic [31:0] O_RM_REG [32];

    modport master (
        output I_MIPS_WrPM, I_MIPS_WrDataPM,
        input  O_PC, O_PC_NEXT, O_ID_PC, O_ID_INSTR, O_EXE_CONTROL, O_MEM_CONTROL, O_WB_CONTROL,
        input  O_EXE_PC, O_EXE_READ_DATA1, O_EXE_READ_DATA2, O_EXE_SIGN_EXT, O_EXE_SHIFT,
        input  O_EXE_RS, O_EXE_RT, O_EXE_RD, O_MEM_REGDST, O_WB_REGDST,
        input  O_MEM_ALU_RESULT, O_MEM_WRITE_DATA, O_MEM_PC, O_MEM_SHIFT,
        input  O_WB_PC, O_WB_ADDR, O_WB_READ_DATA, O_WB_SHIFT,
        input  O_HZ_IFID_WRITE, O_HZ_PC_WRITE, O_HZ_ID_ControlMux, O_FU_ForwardA, O_FU_ForwardB,
        input  O_PM_REG, O_DM_REG, O_RM_REG
    );

    modport slave (
        input  I_MIPS_WrPM, I_MIPS_WrDataPM,
        output O_PC, O_PC_NEXT, O_ID_PC, O_ID_INSTR, O_EXE_CONTROL, O_MEM_CONTROL, O_WB_CONTROL,
        output O_EXE_PC, O_EXE_READ_DATA1, O_EXE_READ_DATA2, O_EXE_SIGN_EXT, O_EXE_SHIFT,
        output O_EXE_RS, O_EXE_RT, O_EXE_RD, O_MEM_REGDST, O_WB_REGDST,
        output O_MEM_ALU_RESULT, O_MEM_WRITE_DATA, O_MEM_PC, O_MEM_SHIFT,
        output O_WB_PC, O_WB_ADDR, O_WB_READ_DATA, O_WB_SHIFT,
        output O_HZ_IFID_WRITE, O_HZ_PC_WRITE, O_HZ_ID_ControlMux, O_FU_ForwardA, O_FU_ForwardB,
        output O_PM_REG, O_DM_REG, O_RM_REG
    );
endinterface

// File: rtl/mips_pipelined_cpu.sv
// Five-stage MIPS subset core with a serially loaded program memory, load-use stall,
// EX-stage forwarding and redirects resolved in EX. All state is exposed on the debug bus.
module mips_pipelined_cpu (
    input  logic                CLK,
    input  logic                RESET,
    mips_pipelined_cpu_if.slave bus
);
    localparam int MEM_DEPTH = 32;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic       rsv;    logic       zext;   logic       shimm;  logic shvar;
        logic       jreg;   logic       jump;   logic       bne;    logic beq;
        logic [3:0] aluop;  logic       alusrc; logic [1:0] regdst;
        logic       memw;   logic       memr;   logic       regw;   logic [1:0] wbsel;
    } ctrl_t;

    logic [DATA_W-1:0] pm_r [MEM_DEPTH];
    logic [DATA_W-1:0] dm_r [MEM_DEPTH];
    logic [DATA_W-1:0] rm_r [MEM_DEPTH];
    logic [4:0]        wr_ptr_r;
    logic [DATA_W-1:0] pc_r, id_pc_r, id_instr_r;
    ctrl_t             ex_ctrl_r, mem_ctrl_r, wb_ctrl_r, dec_s;
    logic [DATA_W-1:0] ex_pc_r, ex_rd1_r, ex_rd2_r, ex_sext_r, ex_shift_r;
    logic [4:0]        ex_rs_r, ex_rt_r, ex_rd_r;
    logic [25:0]       ex_jidx_r;
    logic [DATA_W-1:0] mem_alu_r, mem_wdata_r, mem_pc_r, mem_shift_r;
    logic [4:0]        mem_regdst_r, wb_regdst_r;
    logic [DATA_W-1:0] wb_pc_r, wb_addr_r, wb_rdata_r, wb_shift_r;

    logic [4:0]        id_rs_s, id_rt_s, shamt_s, ex_regdst_s;
    logic [DATA_W-1:0] sext_s, rd1_s, rd2_s, wb_data_s, mem_fwd_s;
    logic [DATA_W-1:0] op_a_s, op_b_s, alu_b_s, alu_s, target_s, pc_next_s;
    logic [1:0]        fwd_a_s, fwd_b_s;
    logic              wb_we_s, stall_s, redirect_s;

    assign id_rs_s = id_instr_r[25:21];
    assign id_rt_s = id_instr_r[20:16];
    assign sext_s  = dec_s.zext ? {16'd0, id_instr_r[15:0]} : {{16{id_instr_r[15]}}, id_instr_r[15:0]};
    assign wb_we_s = wb_ctrl_r.regw && (wb_regdst_r != 5'd0);
    assign stall_s = ex_ctrl_r.memr && (ex_rt_r != 5'd0) && ((ex_rt_r == id_rs_s) || (ex_rt_r == id_rt_s));

    // Instruction decode into the 20-bit control word; unknown encodings become a NOP.
    always_comb begin
        dec_s = ctrl_t'(20'd0);
        case (id_instr_r[31:26])
            6'h00: begin
                dec_s.regw = 1'b1; dec_s.regdst = 2'b01;
                case (id_instr_r[5:0])
                    6'h20: dec_s.aluop = 4'd0;
                    6'h22: dec_s.aluop = 4'd1;
                    6'h24: dec_s.aluop = 4'd2;
                    6'h25: dec_s.aluop = 4'd3;
                    6'h26: dec_s.aluop = 4'd4;
                    6'h27: dec_s.aluop = 4'd5;
                    6'h2a: dec_s.aluop = 4'd6;
                    6'h00: begin dec_s.aluop = 4'd7; dec_s.shimm = 1'b1; end
                    6'h02: begin dec_s.aluop = 4'd8; dec_s.shimm = 1'b1; end
                    6'h03: begin dec_s.aluop = 4'd9; dec_s.shimm = 1'b1; end
                    6'h04: begin dec_s.aluop = 4'd7; dec_s.shvar = 1'b1; end
                    6'h06: begin dec_s.aluop = 4'd8; dec_s.shvar = 1'b1; end
                    6'h07: begin dec_s.aluop = 4'd9; dec_s.shvar = 1'b1; end
                    6'h08: begin dec_s = ctrl_t'(20'd0); dec_s.jreg = 1'b1; end
                    6'h09: begin dec_s.jreg = 1'b1; dec_s.wbsel = 2'b10; end
                    default: dec_s = ctrl_t'(20'd0);
                endcase
            end
            6'h08: begin dec_s.regw = 1'b1; dec_s.alusrc = 1'b1; end
            6'h0a: begin dec_s.regw = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = 4'd6; end
            6'h0c: begin dec_s.regw = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = 4'd2; dec_s.zext = 1'b1; end
            6'h0d: begin dec_s.regw = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = 4'd3; dec_s.zext = 1'b1; end
            6'h0e: begin dec_s.regw = 1'b1; dec_s.alusrc = 1'b1; dec_s.aluop = 4'd4; dec_s.zext = 1'b1; end
            6'h0f: begin dec_s.regw = 1'b1; dec_s.wbsel = 2'b11; end
            6'h23: begin dec_s.regw = 1'b1; dec_s.memr = 1'b1; dec_s.alusrc = 1'b1; dec_s.wbsel = 2'b01; end
            6'h2b: begin dec_s.memw = 1'b1; dec_s.alusrc = 1'b1; end
            6'h04: dec_s.beq = 1'b1;
            6'h05: dec_s.bne = 1'b1;
            6'h02: dec_s.jump = 1'b1;
            6'h03: begin dec_s.jump = 1'b1; dec_s.regw = 1'b1; dec_s.regdst = 2'b10; dec_s.wbsel = 2'b10; end
            default: dec_s = ctrl_t'(20'd0);
        endcase
    end

    // Write-back mux and the EX/MEM value offered for forwarding (DM is read asynchronously).
    always_comb begin
        case (wb_ctrl_r.wbsel)
            2'b00:   wb_data_s = wb_addr_r;
            2'b01:   wb_data_s = wb_rdata_r;
            2'b10:   wb_data_s = wb_pc_r;
            default: wb_data_s = wb_shift_r;
        endcase
        case (mem_ctrl_r.wbsel)
            2'b00:   mem_fwd_s = mem_alu_r;
            2'b01:   mem_fwd_s = dm_r[mem_alu_r[6:2]];
            2'b10:   mem_fwd_s = mem_pc_r;
            default: mem_fwd_s = mem_shift_r;
        endcase
    end

    // Register file read with write-through of the value being written back this cycle.
    always_comb begin
        if (id_rs_s == 5'd0)                            rd1_s = 32'd0;
        else if (wb_we_s && (wb_regdst_r == id_rs_s))   rd1_s = wb_data_s;
        else                                            rd1_s = rm_r[id_rs_s];
        if (id_rt_s == 5'd0)                            rd2_s = 32'd0;
        else if (wb_we_s && (wb_regdst_r == id_rt_s))   rd2_s = wb_data_s;
        else                                            rd2_s = rm_r[id_rt_s];
    end

    // Forwarding selection; EX/MEM wins over MEM/WB.
    always_comb begin
        if (mem_ctrl_r.regw && (mem_regdst_r != 5'd0) && (mem_regdst_r == ex_rs_r)) fwd_a_s = 2'b10;
        else if (wb_we_s && (wb_regdst_r == ex_rs_r))                               fwd_a_s = 2'b01;
        else                                                                        fwd_a_s = 2'b00;
        if (mem_ctrl_r.regw && (mem_regdst_r != 5'd0) && (mem_regdst_r == ex_rt_r)) fwd_b_s = 2'b10;
        else if (wb_we_s && (wb_regdst_r == ex_rt_r))                               fwd_b_s = 2'b01;
        else                                                                        fwd_b_s = 2'b00;
        case (fwd_a_s)
            2'b10:   op_a_s = mem_fwd_s;
            2'b01:   op_a_s = wb_data_s;
            default: op_a_s = ex_rd1_r;
        endcase
        case (fwd_b_s)
            2'b10:   op_b_s = mem_fwd_s;
            2'b01:   op_b_s = wb_data_s;
            default: op_b_s = ex_rd2_r;
        endcase
    end

    // ALU, destination select and redirect resolution. Shifts operate on rt.
    always_comb begin
        alu_b_s = ex_ctrl_r.alusrc ? ex_sext_r : op_b_s;
        shamt_s = ex_ctrl_r.shvar ? op_a_s[4:0] : ex_sext_r[10:6];
        case (ex_ctrl_r.aluop)
            4'd0:    alu_s = op_a_s + alu_b_s;
            4'd1:    alu_s = op_a_s - alu_b_s;
            4'd2:    alu_s = op_a_s & alu_b_s;
            4'd3:    alu_s = op_a_s | alu_b_s;
            4'd4:    alu_s = op_a_s ^ alu_b_s;
            4'd5:    alu_s = ~(op_a_s | alu_b_s);
            4'd6:    alu_s = {31'd0, $signed(op_a_s) < $signed(alu_b_s)};
            4'd7:    alu_s = op_b_s << shamt_s;
            4'd8:    alu_s = op_b_s >> shamt_s;
            4'd9:    alu_s = 32'($signed(op_b_s) >>> shamt_s);
            default: alu_s = 32'd0;
        endcase
        case (ex_ctrl_r.regdst)
            2'b01:   ex_regdst_s = ex_rd_r;
            2'b10:   ex_regdst_s = 5'd31;
            default: ex_regdst_s = ex_rt_r;
        endcase
        redirect_s = 1'b1;
        if (ex_ctrl_r.jreg)      target_s = op_a_s;
        else if (ex_ctrl_r.jump) target_s = {ex_pc_r[31:28], ex_jidx_r, 2'b00};
        else if ((ex_ctrl_r.beq && (op_a_s == op_b_s)) || (ex_ctrl_r.bne && (op_a_s != op_b_s)))
            target_s = ex_pc_r + {ex_sext_r[29:0], 2'b00};
        else begin
            target_s   = 32'd0;
            redirect_s = 1'b0;
        end
        pc_next_s = redirect_s ? target_s : pc_r + 32'd4;
    end

    // Program memory: loaded serially, kept across reset.
    always_ff @(posedge CLK) begin
        if (!RESET && bus.I_MIPS_WrPM) pm_r[wr_ptr_r] <= bus.I_MIPS_WrDataPM;
    end

    // Pipeline, PC, load pointer and data/register memories; frozen while the program loads.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_r <= 32'd0; wr_ptr_r <= 5'd0; id_pc_r <= 32'd0; id_instr_r <= 32'd0;
            ex_ctrl_r <= ctrl_t'(20'd0); ex_pc_r <= 32'd0; ex_rd1_r <= 32'd0; ex_rd2_r <= 32'd0;
            ex_sext_r <= 32'd0; ex_shift_r <= 32'd0; ex_rs_r <= 5'd0; ex_rt_r <= 5'd0;
            ex_rd_r <= 5'd0; ex_jidx_r <= 26'd0;
            mem_ctrl_r <= ctrl_t'(20'd0); mem_alu_r <= 32'd0; mem_wdata_r <= 32'd0;
            mem_pc_r <= 32'd0; mem_shift_r <= 32'd0; mem_regdst_r <= 5'd0;
            wb_ctrl_r <= ctrl_t'(20'd0); wb_pc_r <= 32'd0; wb_addr_r <= 32'd0;
            wb_rdata_r <= 32'd0; wb_shift_r <= 32'd0; wb_regdst_r <= 5'd0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                dm_r[i] <= 32'd0;
                rm_r[i] <= 32'd0;
            end
        end else if (bus.I_MIPS_WrPM) begin
            wr_ptr_r <= wr_ptr_r + 5'd1;
        end else begin
            if (redirect_s || !stall_s) pc_r <= pc_next_s;
            if (redirect_s) begin
                id_pc_r <= 32'd0; id_instr_r <= 32'd0;
            end else if (!stall_s) begin
                id_pc_r <= pc_r + 32'd4; id_instr_r <= pm_r[pc_r[6:2]];
            end
            ex_ctrl_r  <= (redirect_s || stall_s) ? ctrl_t'(20'd0) : dec_s;
            ex_pc_r    <= redirect_s ? 32'd0 : id_pc_r;
            ex_rd1_r   <= redirect_s ? 32'd0 : rd1_s;
            ex_rd2_r   <= redirect_s ? 32'd0 : rd2_s;
            ex_sext_r  <= redirect_s ? 32'd0 : sext_s;
            ex_shift_r <= redirect_s ? 32'd0 : {id_instr_r[15:0], 16'd0};
            ex_rs_r    <= redirect_s ? 5'd0 : id_rs_s;
            ex_rt_r    <= redirect_s ? 5'd0 : id_rt_s;
            ex_rd_r    <= redirect_s ? 5'd0 : id_instr_r[15:11];
            ex_jidx_r  <= redirect_s ? 26'd0 : id_instr_r[25:0];
            mem_ctrl_r <= ex_ctrl_r; mem_alu_r <= alu_s; mem_wdata_r <= op_b_s;
            mem_pc_r <= ex_pc_r; mem_shift_r <= ex_shift_r; mem_regdst_r <= ex_regdst_s;
            wb_ctrl_r <= mem_ctrl_r; wb_pc_r <= mem_pc_r; wb_addr_r <= mem_alu_r;
            wb_rdata_r <= dm_r[mem_alu_r[6:2]]; wb_shift_r <= mem_shift_r; wb_regdst_r <= mem_regdst_r;
            if (mem_ctrl_r.memw) dm_r[mem_alu_r[6:2]] <= mem_wdata_r;
            if (wb_we_s) rm_r[wb_regdst_r] <= wb_data_s;
        end
    end

    assign bus.O_PC = pc_r;                   assign bus.O_PC_NEXT = pc_next_s;
    assign bus.O_ID_PC = id_pc_r;             assign bus.O_ID_INSTR = id_instr_r;
    assign bus.O_EXE_CONTROL = ex_ctrl_r;     assign bus.O_EXE_PC = ex_pc_r;
    assign bus.O_EXE_READ_DATA1 = ex_rd1_r;   assign bus.O_EXE_READ_DATA2 = ex_rd2_r;
    assign bus.O_EXE_SIGN_EXT = ex_sext_r;    assign bus.O_EXE_SHIFT = ex_shift_r;
    assign bus.O_EXE_RS = ex_rs_r;            assign bus.O_EXE_RT = ex_rt_r;
    assign bus.O_EXE_RD = ex_rd_r;            assign bus.O_MEM_CONTROL = mem_ctrl_r;
    assign bus.O_MEM_ALU_RESULT = mem_alu_r;  assign bus.O_MEM_WRITE_DATA = mem_wdata_r;
    assign bus.O_MEM_PC = mem_pc_r;           assign bus.O_MEM_SHIFT = mem_shift_r;
    assign bus.O_MEM_REGDST = mem_regdst_r;   assign bus.O_WB_CONTROL = wb_ctrl_r;
    assign bus.O_WB_PC = wb_pc_r;             assign bus.O_WB_ADDR = wb_addr_r;
    assign bus.O_WB_READ_DATA = wb_rdata_r;   assign bus.O_WB_SHIFT = wb_shift_r;
    assign bus.O_WB_REGDST = wb_regdst_r;
    assign bus.O_HZ_IFID_WRITE = !stall_s;    assign bus.O_HZ_PC_WRITE = !stall_s;
    assign bus.O_HZ_ID_ControlMux = stall_s;
    assign bus.O_FU_ForwardA = fwd_a_s;       assign bus.O_FU_ForwardB = fwd_b_s;

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_dbg
        assign bus.O_PM_REG[g] = pm_r[g];
        assign bus.O_DM_REG[g] = dm_r[g];
        assign bus.O_RM_REG[g] = rm_r[g];
    end
endmodule

// File: tb/tb_mips_pipelined_cpu.sv
// Directed bench for mips_pipelined_cpu: a register-commit scoreboard plus cycle-exact
// checks of PC flow, stall, forwarding selects, redirects and mid-run reset.
module tb_mips_pipelined_cpu;
    logic CLK;
    logic RESET;
    mips_pipelined_cpu_if bus ();

    mips_pipelined_cpu dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en  = 1'b0;
    logic [31:0] prog [32];
    logic [4:0]  exp_dst [$];
    logic [31:0] exp_val [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic expect_wb(input logic [4:0] dst, input logic [31:0] val);
        exp_dst.push_back(dst);
        exp_val.push_back(val);
    endtask

    // Monitor: each register commit leaving WB is matched in order, and the register
    // file is checked one cycle later for the expected value.
    initial begin
        logic        pend = 1'b0;
        logic [4:0]  pend_dst = 5'd0;
        logic [31:0] pend_val = 32'd0;
        forever begin
            @(negedge CLK);
            if (pend) begin
                chk("wb_commit_value", bus.O_RM_REG[pend_dst], pend_val);
                pend = 1'b0;
            end
            if (mon_en && bus.O_WB_CONTROL[2] && (bus.O_WB_REGDST != 5'd0)) begin
                if (exp_dst.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got reg %0d expected none", bus.O_WB_REGDST);
                end else begin
                    pend_dst = exp_dst.pop_front();
                    pend_val = exp_val.pop_front();
                    chk("wb_commit_dst", {27'd0, bus.O_WB_REGDST}, {27'd0, pend_dst});
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        int stalls = 0;
        int bad    = 0;
        for (int i = 0; i < 32; i++) prog[i] = 32'd0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // ADDI $1,$0,5
        prog[1]  = enc_i(6'h08, 5'd1, 5'd2, 16'd3);        // ADDI $2,$1,3
        prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);         // ADD  $3,$1,$2
        prog[3]  = enc_i(6'h2b, 5'd0, 5'd3, 16'd4);        // SW   $3,4($0)
        prog[4]  = enc_i(6'h23, 5'd0, 5'd4, 16'd4);        // LW   $4,4($0)
        prog[5]  = enc_i(6'h08, 5'd4, 5'd5, 16'd1);        // ADDI $5,$4,1
        prog[6]  = enc_i(6'h04, 5'd0, 5'd0, 16'd2);        // BEQ  $0,$0,+2
        prog[7]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);        // ADDI $6 (flushed)
        prog[8]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);        // ADDI $6 (flushed)
        prog[9]  = enc_j(6'h02, 26'd12);                   // J    12
        prog[10] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);        // JR   $31
        prog[12] = enc_j(6'h03, 26'd10);                   // JAL  10
        prog[13] = enc_i(6'h0f, 5'd0, 5'd7, 16'h1234);     // LUI  $7,0x1234
        prog[14] = enc_i(6'h0d, 5'd7, 5'd7, 16'h5678);     // ORI  $7,$7,0x5678
        prog[15] = enc_j(6'h02, 26'd15);                   // J    15 (halt loop)
        expect_wb(5'd1, 32'd5);
        expect_wb(5'd2, 32'd8);
        expect_wb(5'd3, 32'd13);
        expect_wb(5'd4, 32'd13);
        expect_wb(5'd5, 32'd14);
        expect_wb(5'd31, 32'd52);
        expect_wb(5'd7, 32'h12340000);
        expect_wb(5'd7, 32'h12345678);

        RESET = 1'b1;
        bus.I_MIPS_WrPM = 1'b0;
        bus.I_MIPS_WrDataPM = 32'd0;
        #9;
        chk("reset_pc", bus.O_PC, 32'd0);
        for (int i = 0; i < 32; i++)
            if ((bus.O_RM_REG[i] !== 32'd0) || (bus.O_DM_REG[i] !== 32'd0)) bad++;
        chk("reset_rm_dm_zero", bad, 32'd0);

        RESET = 1'b0;
        bus.I_MIPS_WrPM = 1'b1;
        bus.I_MIPS_WrDataPM = prog[0];
        for (int i = 1; i < 32; i++) begin
            @(posedge CLK); #1;
            bus.I_MIPS_WrDataPM = prog[i];
        end
        @(posedge CLK); #1;
        bus.I_MIPS_WrPM = 1'b0;
        mon_en = 1'b1;

        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (!bus.O_HZ_PC_WRITE) stalls++;
            case (c)
                0:  chk("pc_c0", bus.O_PC, 32'd0);
                1:  chk("pc_c1", bus.O_PC, 32'd4);
                2:  chk("pc_c2", bus.O_PC, 32'd8);
                3:  chk("fwdA_addi", {30'd0, bus.O_FU_ForwardA}, 32'd2);
                4: begin
                    chk("fwdA_add", {30'd0, bus.O_FU_ForwardA}, 32'd1);
                    chk("fwdB_add", {30'd0, bus.O_FU_ForwardB}, 32'd2);
                end
                5:  chk("fwdB_sw", {30'd0, bus.O_FU_ForwardB}, 32'd2);
                6: begin
                    chk("stall_pcwrite", {31'd0, bus.O_HZ_PC_WRITE}, 32'd0);
                    chk("stall_ifidwrite", {31'd0, bus.O_HZ_IFID_WRITE}, 32'd0);
                    chk("stall_ctrlmux", {31'd0, bus.O_HZ_ID_ControlMux}, 32'd1);
                    chk("stall_pc", bus.O_PC, 32'd24);
                end
                7: begin
                    chk("held_pc", bus.O_PC, 32'd24);
                    chk("bubble_ctrl", {12'd0, bus.O_EXE_CONTROL}, 32'd0);
                end
                8:  chk("fwdA_load", {30'd0, bus.O_FU_ForwardA}, 32'd1);
                9:  chk("beq_target", bus.O_PC_NEXT, 32'd36);
                10: begin
                    chk("beq_landed", bus.O_PC, 32'd36);
                    chk("flush_ifid", bus.O_ID_INSTR, 32'd0);
                    chk("flush_idex", {12'd0, bus.O_EXE_CONTROL}, 32'd0);
                end
                12: chk("j_target", bus.O_PC_NEXT, 32'd48);
                15: chk("jal_target", bus.O_PC_NEXT, 32'd40);
                18: begin
                    chk("jr_rs_value", bus.O_EXE_READ_DATA1, 32'd52);
                    chk("jr_target", bus.O_PC_NEXT, 32'd52);
                end
                19: chk("jr_return_pc", bus.O_PC, 32'd52);
                default: ;
            endcase
        end

        chk("stall_cycles", stalls, 32'd1);
        chk("sb_drained", 32'(exp_dst.size()), 32'd0);
        chk("rm1", bus.O_RM_REG[1], 32'd5);
        chk("rm2", bus.O_RM_REG[2], 32'd8);
        chk("rm3", bus.O_RM_REG[3], 32'd13);
        chk("rm5", bus.O_RM_REG[5], 32'd14);
        chk("rm6_flushed", bus.O_RM_REG[6], 32'd0);
        chk("rm7", bus.O_RM_REG[7], 32'h12345678);
        chk("rm31", bus.O_RM_REG[31], 32'd52);
        chk("dm1", bus.O_DM_REG[1], 32'd13);

        mon_en = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("mid_reset_pc", bus.O_PC, 32'd0);
        chk("mid_reset_id_instr", bus.O_ID_INSTR, 32'd0);
        chk("mid_reset_id_pc", bus.O_ID_PC, 32'd0);
        chk("mid_reset_ex_ctrl", {12'd0, bus.O_EXE_CONTROL}, 32'd0);
        chk("mid_reset_ex_pc", bus.O_EXE_PC, 32'd0);
        chk("mid_reset_mem_ctrl", {12'd0, bus.O_MEM_CONTROL}, 32'd0);
        chk("mid_reset_wb_ctrl", {12'd0, bus.O_WB_CONTROL}, 32'd0);
        chk("mid_reset_wb_pc", bus.O_WB_PC, 32'd0);
        chk("mid_reset_rm7", bus.O_RM_REG[7], 32'd0);
        chk("mid_reset_dm1", bus.O_DM_REG[1], 32'd0);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (bus.O_PM_REG[i] !== prog[i]) bad++;
        chk("pm_retained", bad, 32'd0);
        RESET = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
